dmem_responder: RTL and testbench

Data-memory responder serving the core's load/store unit on its memory request interface. It accepts one word read or write per request from `read_mem`/`write_mem`/`addr`/`write_data`, performs it on an internal word array after a configurable latency, and returns `mem_done` with `DCache_data`. It sits beside the core in the top level, in place of a data cache, and is the completing end of the core's memory handshake.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_BITS = 32;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        i_addr,
  input  logic                 i_we,
  input  logic [WORD_BITS-1:0] i_wdata,
  input  logic                 i_re,
  input  logic                 i_clr,
  output logic [WORD_BITS-1:0] o_rdata
);

  logic [WORD_BITS-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_BITS-1:0] r_rdata;

  // Storage has no reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register holds its value between reads; i_clr returns zero for out-of-range reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one word read/write per request, completing after LATENCY cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_mem,
  input  logic                 write_mem,
  input  logic [31:0]          addr,
  input  logic                 addr_valid,
  input  logic [WORD_BITS-1:0] write_data,
  input  logic                 write_data_valid,
  output logic                 mem_done,
  output logic [WORD_BITS-1:0] DCache_data,
  output logic                 busy,
  output logic                 err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  dmem_state_t          r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_arm;
  logic [29:0]          r_widx;
  logic                 r_misalign;
  logic                 r_type;
  logic [WORD_BITS-1:0] r_wdata;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_err;

  dmem_state_t          w_next;
  logic [CW-1:0]        w_cnt_next;
  logic                 w_req;
  logic                 w_capture_req;
  logic                 w_capture_data;
  logic                 w_illegal;
  logic                 w_arm_next;
  logic                 w_in_range;
  logic                 w_last_busy;
  logic                 w_rd_en;
  logic                 w_rd_clr;
  logic                 w_wr_en;
  logic                 w_err_next;

  assign w_req      = addr_valid & r_arm;
  assign w_in_range = ({2'b00, r_widx} < 32'(DEPTH_WORDS));

  always_comb begin
    w_next         = r_state;
    w_cnt_next     = r_cnt;
    w_capture_req  = 1'b0;
    w_capture_data = 1'b0;
    w_illegal      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && (read_mem ^ write_mem)) begin
          w_capture_req = 1'b1;
          if (read_mem) begin
            w_next     = BUSY;
            w_cnt_next = CNT_LOAD;
          end else if (write_data_valid) begin
            w_capture_data = 1'b1;
            w_next         = BUSY;
            w_cnt_next     = CNT_LOAD;
          end else begin
            w_next = WDATA;
          end
        end else if (w_req && read_mem && write_mem) begin
          w_illegal = 1'b1;
        end
      end
      WDATA: begin
        if (write_data_valid) begin
          w_capture_data = 1'b1;
          w_next         = BUSY;
          w_cnt_next     = CNT_LOAD;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // A low addr_valid re-arms even in RESP, so one idle cycle is enough between requests.
  always_comb begin
    w_arm_next = r_arm;
    if (!addr_valid) begin
      w_arm_next = 1'b1;
    end else if (r_state == RESP || w_illegal) begin
      w_arm_next = 1'b0;
    end
  end

  assign w_err_next = w_illegal | ((w_next == RESP) & (~w_in_range | r_misalign));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_arm      <= 1'b1;
      r_widx     <= '0;
      r_misalign <= 1'b0;
      r_type     <= REQ_READ;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_arm   <= w_arm_next;
      if (w_capture_req) begin
        r_widx     <= addr[31:2];
        r_misalign <= (addr[1:0] != 2'b00);
        r_type     <= read_mem ? REQ_READ : REQ_WRITE;
      end
      if (w_capture_data) begin
        r_wdata <= write_data;
      end
      r_done <= (w_next == RESP);
      r_busy <= (w_next != IDLE);
      r_err  <= w_err_next;
    end
  end

  // The RAM read is issued in the last BUSY cycle so its data lands with mem_done.
  assign w_last_busy = (r_state == BUSY) && (r_cnt == '0);
  assign w_rd_en     = w_last_busy && (r_type == REQ_READ) && w_in_range;
  assign w_rd_clr    = w_last_busy && (r_type == REQ_READ) && !w_in_range;
  assign w_wr_en     = (r_state == RESP) && (r_type == REQ_WRITE) && w_in_range && !rst;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .i_addr (r_widx[AW-1:0]),
    .i_we   (w_wr_en),
    .i_wdata(r_wdata),
    .i_re   (w_rd_en),
    .i_clr  (w_rd_clr),
    .o_rdata(DCache_data)
  );

  assign mem_done = r_done;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int SDEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0, av = 1'b0, wdv = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        done, busy, err;
  logic [31:0] data;

  logic        s_rd = 1'b0, s_wr = 1'b0, s_av = 1'b0, s_wdv = 1'b0;
  logic [31:0] s_addr = '0, s_wdata = '0;
  logic        l1_done, l1_busy, l1_err, l5_done, l5_busy, l5_err;
  logic [31:0] l1_data, l5_data;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] model [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .read_mem(rd), .write_mem(wr), .addr(addr), .addr_valid(av),
    .write_data(wdata), .write_data_valid(wdv), .mem_done(done), .DCache_data(data),
    .busy(busy), .err(err));

  dmem_responder #(.DEPTH_WORDS(SDEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .read_mem(s_rd), .write_mem(s_wr), .addr(s_addr), .addr_valid(s_av),
    .write_data(s_wdata), .write_data_valid(s_wdv), .mem_done(l1_done), .DCache_data(l1_data),
    .busy(l1_busy), .err(l1_err));

  dmem_responder #(.DEPTH_WORDS(SDEPTH), .LATENCY(5)) dut_l5 (
    .clk(clk), .rst(rst), .read_mem(s_rd), .write_mem(s_wr), .addr(s_addr), .addr_valid(s_av),
    .write_data(s_wdata), .write_data_valid(s_wdv), .mem_done(l5_done), .DCache_data(l5_data),
    .busy(l5_busy), .err(l5_err));

  // Drives one request, holds it until completion (and at least holdCycles), then drops it.
  task automatic drive_req(input logic isWrite, input logic [31:0] a, input logic [31:0] d,
                           input int dataDelay, input int holdCycles, output int lat,
                           output int doneCnt, output logic errAtDone, output logic [31:0] dataAtDone);
    int k;
    lat = -1; doneCnt = 0; errAtDone = 1'b0; dataAtDone = '0;
    @(posedge clk); #1;
    av = 1'b1; rd = !isWrite; wr = isWrite; addr = a; wdata = d;
    wdv = isWrite && (dataDelay == 0);
    @(posedge clk);
    if (isWrite && dataDelay > 0) begin
      repeat (dataDelay - 1) @(posedge clk);
      #1 wdv = 1'b1;
      @(posedge clk);
    end
    #1 wdv = 1'b0;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (done) begin
        doneCnt++;
        if (lat < 0) begin
          lat = k; errAtDone = err; dataAtDone = data;
        end
      end
      if (lat >= 0 && k >= holdCycles) break;
    end
    @(posedge clk); #1;
    av = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input int idx);
    if (idx >= DEPTH) return 32'h0;
    if (model.exists(idx)) return model[idx];
    return 32'h0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done got %b want 0", done); end
    testsRun++; if (data !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_data got %h want 0", data); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err got %b want 0", err); end
    testsRun++; if ({l1_busy, l5_busy, l1_done, l5_done} !== 4'b0) begin testsFailed++;
      $display("[TB] FAIL reset_sweep got %b want 0000", {l1_busy, l5_busy, l1_done, l5_done}); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, n; logic e; logic [31:0] d;
    drive_req(1'b1, 32'h10, 32'hDEADBEEF, 0, 0, lat, n, e, d);
    model[4] = 32'hDEADBEEF;
    testsRun++; if (lat != 2 || n != 1 || e !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL wr_0x10 got lat=%0d n=%0d err=%b want lat=2 n=1 err=0", lat, n, e); end
    drive_req(1'b0, 32'h10, 32'h0, 0, 0, lat, n, e, d);
    testsRun++; if (lat != 2 || n != 1 || e !== 1'b0 || d !== 32'hDEADBEEF) begin testsFailed++;
      $display("[TB] FAIL rd_0x10 got lat=%0d n=%0d err=%b data=%h want 2 1 0 deadbeef", lat, n, e, d); end
  endtask

  task automatic test_late_wdata();
    int lat, n; logic e; logic [31:0] d;
    drive_req(1'b1, 32'h20, 32'h12345678, 3, 0, lat, n, e, d);
    model[8] = 32'h12345678;
    testsRun++; if (lat != 2 || n != 1 || e !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL late_wr got lat=%0d n=%0d err=%b want lat=2 n=1 err=0", lat, n, e); end
    drive_req(1'b0, 32'h20, 32'h0, 0, 0, lat, n, e, d);
    testsRun++; if (lat != 2 || d !== 32'h12345678) begin testsFailed++;
      $display("[TB] FAIL late_rd got lat=%0d data=%h want 2 12345678", lat, d); end
  endtask

  task automatic test_held_request();
    int lat, n; logic e; logic [31:0] d;
    drive_req(1'b0, 32'h10, 32'h0, 0, 10, lat, n, e, d);
    testsRun++; if (n != 1 || d !== model_read(4)) begin testsFailed++;
      $display("[TB] FAIL held_req got pulses=%0d data=%h want 1 %h", n, d, model_read(4)); end
  endtask

  task automatic test_errors();
    int lat, n, errCnt, doneCnt, busyCnt; logic e; logic [31:0] d;
    @(posedge clk); #1;
    av = 1'b1; rd = 1'b1; wr = 1'b1; addr = 32'h40;
    errCnt = 0; doneCnt = 0; busyCnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (err) errCnt++;
      if (done) doneCnt++;
      if (busy) busyCnt++;
    end
    @(posedge clk); #1 av = 1'b0; rd = 1'b0; wr = 1'b0;
    testsRun++; if (errCnt != 1 || doneCnt != 0 || busyCnt != 0) begin testsFailed++;
      $display("[TB] FAIL illegal_req got err=%0d done=%0d busy=%0d want 1 0 0", errCnt, doneCnt, busyCnt); end
    drive_req(1'b0, 32'(4 * DEPTH), 32'h0, 0, 0, lat, n, e, d);
    testsRun++; if (lat != 2 || d !== 32'h0 || e !== 1'b1) begin testsFailed++;
      $display("[TB] FAIL oor_read got lat=%0d data=%h err=%b want 2 0 1", lat, d, e); end
    drive_req(1'b1, 32'h13, 32'hCAFEF00D, 0, 0, lat, n, e, d);
    model[4] = 32'hCAFEF00D;
    testsRun++; if (lat != 2 || e !== 1'b1) begin testsFailed++;
      $display("[TB] FAIL misaligned_wr got lat=%0d err=%b want 2 1", lat, e); end
    drive_req(1'b0, 32'h10, 32'h0, 0, 0, lat, n, e, d);
    testsRun++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL misaligned_rdback got data=%h err=%b want cafef00d 0", d, e); end
  endtask

  task automatic test_reset_mid_op();
    int lat, n, doneCnt; logic e; logic [31:0] d;
    drive_req(1'b1, 32'h30, 32'h11111111, 0, 0, lat, n, e, d);
    model[12] = 32'h11111111;
    drive_req(1'b0, 32'h30, 32'h0, 0, 0, lat, n, e, d);
    @(posedge clk); #1;
    av = 1'b1; wr = 1'b1; rd = 1'b0; addr = 32'h30; wdata = 32'hAAAA5555; wdv = 1'b1;
    @(posedge clk); #1;
    av = 1'b0; wr = 1'b0; wdv = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    testsRun++; if ({done, busy, err} !== 3'b000 || data !== 32'h0) begin testsFailed++;
      $display("[TB] FAIL mid_reset_outputs got done=%b busy=%b err=%b data=%h want 0 0 0 0", done, busy, err, data); end
    @(posedge clk); #1 rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    testsRun++; if (doneCnt != 0) begin testsFailed++;
      $display("[TB] FAIL mid_reset_nodone got %0d pulses want 0", doneCnt); end
    drive_req(1'b0, 32'h30, 32'h0, 0, 0, lat, n, e, d);
    testsRun++; if (d !== 32'h11111111) begin testsFailed++;
      $display("[TB] FAIL mid_reset_rdback got %h want 11111111", d); end
  endtask

  task automatic test_random();
    int lat, n, idx, dly; logic e, isWr, expErr; logic [31:0] d, a, wd, expData;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      drive_req(1'b1, 32'(i * 4), wd, 0, 0, lat, n, e, d);
      model[i] = wd;
      testsRun++; if (lat != 2 || n != 1 || e !== 1'b0) begin testsFailed++;
        $display("[TB] FAIL fill_%0d got lat=%0d n=%0d err=%b want 2 1 0", i, lat, n, e); end
    end
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) idx = DEPTH + $urandom_range(0, 7);
      else idx = $urandom_range(0, 15);
      a = 32'(idx * 4);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      isWr = $urandom_range(0, 1) == 1;
      wd = $urandom;
      dly = $urandom_range(0, 3);
      expErr = (idx >= DEPTH) || (a[1:0] != 2'b00);
      expData = model_read(idx);
      drive_req(isWr, a, wd, dly, 0, lat, n, e, d);
      if (isWr && idx < DEPTH) model[idx] = wd;
      testsRun++;
      if (lat != 2 || n != 1 || e !== expErr || (!isWr && d !== expData)) begin testsFailed++;
        $display("[TB] FAIL rand_%0d wr=%b a=%h got lat=%0d n=%0d err=%b data=%h want 2 1 %b %h",
                 t, isWr, a, lat, n, e, d, expErr, expData); end
    end
  endtask

  task automatic test_latency_sweep();
    int k, lat1, lat5, n1, n5; logic [31:0] d1, d5, wd; logic isWr;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      for (int ph = 0; ph < 2; ph++) begin
        isWr = (ph == 0);
        lat1 = -1; lat5 = -1; n1 = 0; n5 = 0; d1 = '0; d5 = '0;
        @(posedge clk); #1;
        s_av = 1'b1; s_rd = !isWr; s_wr = isWr; s_addr = 32'(i * 4); s_wdata = wd; s_wdv = isWr;
        @(posedge clk); #1 s_wdv = 1'b0;
        k = 0;
        while (k < 20) begin
          @(posedge clk);
          k++;
          @(negedge clk);
          if (l1_done) begin n1++; if (lat1 < 0) begin lat1 = k; d1 = l1_data; end end
          if (l5_done) begin n5++; if (lat5 < 0) begin lat5 = k; d5 = l5_data; end end
          if (lat1 >= 0 && lat5 >= 0 && k >= 7) break;
        end
        @(posedge clk); #1 s_av = 1'b0; s_rd = 1'b0; s_wr = 1'b0;
        testsRun++; if (lat1 != 1 || lat5 != 5 || n1 != 1 || n5 != 1) begin testsFailed++;
          $display("[TB] FAIL sweep_lat_%0d_%0d got l1=%0d/%0d l5=%0d/%0d want 1/1 5/1", i, ph, lat1, n1, lat5, n5); end
        if (!isWr) begin
          testsRun++; if (d1 !== wd || d5 !== wd) begin testsFailed++;
            $display("[TB] FAIL sweep_data_%0d got l1=%h l5=%h want %h", i, d1, d5, wd); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_late_wdata();
    test_held_request();
    test_errors();
    test_reset_mid_op();
    test_random();
    test_latency_sweep();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
